// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data stages, with a fixed read latency LAT.
// Optional macro ARB_FAIR_EN: simultaneous requests alternate winners instead of the data stage always winning.
module mem_port_arbiter #(
   parameter int Bits = 64,
   parameter int LAT  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [31:0]     if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [31:0]     if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [31:0]     d_addr,
   input  logic [Bits-1:0] d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [Bits-1:0] d_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [31:0]     mem_addr,
   output logic [Bits-1:0] mem_wdata,
   input  logic [Bits-1:0] mem_rdata,
   output logic            stall_if,
   output logic            stall_mem
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] CntLoad = 4'(LAT - 1);

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic       owner, owner_next;
   logic       store_q, store_next;
   logic       grant_ok, pick_data;
   logic       capture, cap_owner, cap_store;
`ifdef ARB_FAIR_EN
   logic       last_grant, last_grant_next;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      owner_next = owner;
      store_next = store_q;
`ifdef ARB_FAIR_EN
      last_grant_next = last_grant;
      pick_data = d_req & (~if_req | ~last_grant);
`else
      pick_data = d_req;
`endif
      // cnt==0 in BUSY marks the response cycle, when the port can be handed on
      grant_ok  = (state == IDLE) || (cnt == 4'd0);
      d_gnt     = grant_ok & pick_data;
      if_gnt    = grant_ok & if_req & ~pick_data;
      mem_en    = d_gnt | if_gnt;
      mem_we    = d_we & d_gnt;
      mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : 32'd0);
      mem_wdata = d_gnt ? d_wdata : '0;

      if (mem_en) begin
         state_next = BUSY;
         cnt_next   = CntLoad;
         owner_next = d_gnt;
         store_next = mem_we;
`ifdef ARB_FAIR_EN
         last_grant_next = d_gnt;
`endif
      end else if (state == BUSY) begin
         if (cnt == 4'd0) state_next = IDLE;
         else             cnt_next   = cnt - 4'd1;
      end

      // With LAT=1 the data arrives in the grant cycle itself, before owner is registered
      if (LAT == 1) begin
         capture   = mem_en;
         cap_owner = d_gnt;
         cap_store = mem_we;
      end else begin
         capture   = (state == BUSY) && (cnt == 4'd1);
         cap_owner = owner;
         cap_store = store_q;
      end
   end

   assign stall_if  = if_req & ~if_gnt;
   assign stall_mem = d_req & ~d_gnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         owner   <= 1'b0;
         store_q <= 1'b0;
`ifdef ARB_FAIR_EN
         last_grant <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         owner   <= owner_next;
         store_q <= store_next;
`ifdef ARB_FAIR_EN
         last_grant <= last_grant_next;
`endif
      end
   end

   // Response capture: stores pulse d_rvalid but leave d_rdata untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= 32'd0;
         d_rdata   <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if (capture) begin
            if (cap_owner) begin
               d_rvalid <= 1'b1;
               if (!cap_store) d_rdata <= mem_rdata;
            end else begin
               if_rvalid <= 1'b1;
               if_rdata  <= mem_rdata[31:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at LAT=1, 2 and 3 share one stimulus set.
module tb_mem_port_arbiter;

`ifdef ARB_FAIR_EN
   localparam bit Fair = 1'b1;
`else
   localparam bit Fair = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr;
   logic [63:0] d_wdata, mem_rdata;
   int n_checks = 0;
   int n_fail = 0;

   logic if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1, stall_if_1, stall_mem_1;
   logic if_gnt_2, if_rvalid_2, d_gnt_2, d_rvalid_2, mem_en_2, mem_we_2, stall_if_2, stall_mem_2;
   logic if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, stall_if_3, stall_mem_3;
   logic [31:0] if_rdata_1, mem_addr_1, if_rdata_2, mem_addr_2, if_rdata_3, mem_addr_3;
   logic [63:0] d_rdata_1, mem_wdata_1, d_rdata_2, mem_wdata_2, d_rdata_3, mem_wdata_3;

   always #5 clk = ~clk;

   mem_port_arbiter #(.Bits(64), .LAT(1)) u1 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
      .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1),
      .d_rdata(d_rdata_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
      .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata), .stall_if(stall_if_1), .stall_mem(stall_mem_1));

   mem_port_arbiter #(.Bits(64), .LAT(2)) u2 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_2),
      .if_rvalid(if_rvalid_2), .if_rdata(if_rdata_2), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_2), .d_rvalid(d_rvalid_2),
      .d_rdata(d_rdata_2), .mem_en(mem_en_2), .mem_we(mem_we_2), .mem_addr(mem_addr_2),
      .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata), .stall_if(stall_if_2), .stall_mem(stall_mem_2));

   mem_port_arbiter #(.Bits(64), .LAT(3)) u3 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
      .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3),
      .d_rdata(d_rdata_3), .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
      .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata), .stall_if(stall_if_3), .stall_mem(stall_mem_3));

   // Inputs change on the falling edge; outputs are sampled 1ns later
   task automatic clear_inputs();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'd0; d_addr = 32'd0; d_wdata = 64'd0;
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk); #1;
      n_checks++;
      if ({if_rvalid_1, d_rvalid_1, if_rvalid_2, d_rvalid_2, if_rvalid_3, d_rvalid_3, mem_en_2} !== 7'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_valids: got %b expected 0", {if_rvalid_1, d_rvalid_1, if_rvalid_2, d_rvalid_2, if_rvalid_3, d_rvalid_3, mem_en_2});
      end
      n_checks++;
      if ({if_rdata_2, d_rdata_2, if_rdata_3, d_rdata_3} !== 192'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_rdata: got %h/%h expected 0", if_rdata_2, d_rdata_2);
      end
      @(negedge clk);
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h44;
      #1;
      n_checks++;
      if ({if_gnt_2, mem_en_2} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL first_grant: got gnt,en=%b expected 11", {if_gnt_2, mem_en_2});
      end
      @(negedge clk);
      if_req = 1'b0;
   endtask

   task automatic test_fetch();
      apply_reset();
      if_req = 1'b1; if_addr = 32'h10; #1;
      n_checks++;
      if ({if_gnt_2, d_gnt_2, mem_en_2, mem_we_2, stall_if_2} !== 5'b10100 || mem_addr_2 !== 32'h10) begin
         n_fail++;
         $display("[TB] FAIL fetch_grant: got %b addr=%h expected 10100 addr=10", {if_gnt_2, d_gnt_2, mem_en_2, mem_we_2, stall_if_2}, mem_addr_2);
      end
      @(negedge clk);
      if_req = 1'b0; mem_rdata = 64'h1234_5678_00A0_0093; #1;
      n_checks++;
      if ({if_gnt_2, if_rvalid_2, mem_en_2} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL fetch_busy: got %b expected 000", {if_gnt_2, if_rvalid_2, mem_en_2});
      end
      @(negedge clk);
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      n_checks++;
      if ({if_rvalid_2, d_rvalid_2} !== 2'b10 || if_rdata_2 !== 32'h00A0_0093) begin
         n_fail++;
         $display("[TB] FAIL fetch_resp: got rv=%b rdata=%h expected 10 00a00093", {if_rvalid_2, d_rvalid_2}, if_rdata_2);
      end
      @(negedge clk); #1;
      n_checks++;
      if (if_rvalid_2 !== 1'b0 || if_rdata_2 !== 32'h00A0_0093) begin
         n_fail++;
         $display("[TB] FAIL fetch_hold: got rv=%b rdata=%h expected 0 00a00093", if_rvalid_2, if_rdata_2);
      end
   endtask

   task automatic test_priority();
      apply_reset();
      if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; #1;
      n_checks++;
      if ({d_gnt_2, if_gnt_2, stall_if_2, stall_mem_2} !== 4'b1010 || mem_addr_2 !== 32'h20) begin
         n_fail++;
         $display("[TB] FAIL prio_grant: got %b addr=%h expected 1010 addr=20", {d_gnt_2, if_gnt_2, stall_if_2, stall_mem_2}, mem_addr_2);
      end
      @(negedge clk);
      d_req = 1'b0; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D; #1;
      n_checks++;
      if ({if_gnt_2, stall_if_2, mem_en_2} !== 3'b010) begin
         n_fail++;
         $display("[TB] FAIL prio_wait: got %b expected 010", {if_gnt_2, stall_if_2, mem_en_2});
      end
      @(negedge clk);
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      n_checks++;
      if ({d_rvalid_2, if_gnt_2, stall_if_2} !== 3'b110 || d_rdata_2 !== 64'hDEAD_BEEF_CAFE_F00D || mem_addr_2 !== 32'h40) begin
         n_fail++;
         $display("[TB] FAIL prio_handoff: got %b rdata=%h addr=%h expected 110 deadbeefcafef00d 40", {d_rvalid_2, if_gnt_2, stall_if_2}, d_rdata_2, mem_addr_2);
      end
      @(negedge clk);
      if_req = 1'b0; mem_rdata = 64'h0000_0000_0000_1111; #1;
      n_checks++;
      if ({d_rvalid_2, if_rvalid_2} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL prio_gap: got %b expected 00", {d_rvalid_2, if_rvalid_2});
      end
      @(negedge clk);
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      n_checks++;
      if (if_rvalid_2 !== 1'b1 || if_rdata_2 !== 32'h0000_1111) begin
         n_fail++;
         $display("[TB] FAIL prio_fetch_resp: got rv=%b rdata=%h expected 1 00001111", if_rvalid_2, if_rdata_2);
      end
   endtask

   // Runs straight after test_priority so d_rdata already holds a known load value
   task automatic test_store();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 64'h55; #1;
      n_checks++;
      if ({d_gnt_2, mem_en_2, mem_we_2} !== 3'b111 || mem_wdata_2 !== 64'h55 || mem_addr_2 !== 32'h8) begin
         n_fail++;
         $display("[TB] FAIL store_grant: got %b wdata=%h addr=%h expected 111 55 8", {d_gnt_2, mem_en_2, mem_we_2}, mem_wdata_2, mem_addr_2);
      end
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0; mem_rdata = 64'h0000_0000_0000_9999; #1;
      n_checks++;
      if ({d_rvalid_2, mem_en_2, mem_we_2} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL store_busy: got %b expected 000", {d_rvalid_2, mem_en_2, mem_we_2});
      end
      @(negedge clk); #1;
      n_checks++;
      if (d_rvalid_2 !== 1'b1 || d_rdata_2 !== 64'hDEAD_BEEF_CAFE_F00D) begin
         n_fail++;
         $display("[TB] FAIL store_done: got rv=%b rdata=%h expected 1 deadbeefcafef00d", d_rvalid_2, d_rdata_2);
      end
      @(negedge clk); #1;
      n_checks++;
      if (d_rvalid_2 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL store_pulse: got rv=%b expected 0", d_rvalid_2);
      end
   endtask

   task automatic test_arb_order();
      logic [3:0] exp;
      apply_reset();
      if_req = 1'b1; d_req = 1'b1; if_addr = 32'h100; d_addr = 32'h200;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (k % 2 == 1)                  exp = 4'b0011;
         else if (!Fair || (k / 2) % 2 == 0) exp = 4'b1010;
         else                             exp = 4'b0101;
         n_checks++;
         if ({d_gnt_2, if_gnt_2, stall_if_2, stall_mem_2} !== exp) begin
            n_fail++;
            $display("[TB] FAIL arb_order cycle %0d: got dgnt,ignt,sif,smem=%b expected %b", k, {d_gnt_2, if_gnt_2, stall_if_2, stall_mem_2}, exp);
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; #1;
      n_checks++;
      if ({d_gnt_3, mem_en_3} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL rstmid_grant: got %b expected 11", {d_gnt_3, mem_en_3});
      end
      @(negedge clk);
      d_req = 1'b0; mem_rdata = 64'h0123_4567_89AB_CDEF; rst = 1'b0; #1;
      n_checks++;
      if ({d_rvalid_3, if_rvalid_3, mem_en_3} !== 3'b000 || d_rdata_3 !== 64'd0 || if_rdata_3 !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL rstmid_clear: got %b rdata=%h expected 000 0", {d_rvalid_3, if_rvalid_3, mem_en_3}, d_rdata_3);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if ({d_rvalid_3, mem_en_3} !== 2'b00 || d_rdata_3 !== 64'd0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_quiet cycle %0d: got rv,en=%b rdata=%h expected 00 0", k, {d_rvalid_3, mem_en_3}, d_rdata_3);
         end
         @(negedge clk);
      end
      d_req = 1'b1; #1;
      n_checks++;
      if (d_gnt_3 !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rstmid_idle: got d_gnt=%b expected 1", d_gnt_3);
      end
      @(negedge clk);
      d_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         if_req = 1'b1; if_addr = 32'h100 + 32'(4 * k); mem_rdata = 64'hA0 + 64'(k); #1;
         n_checks++;
         if (if_gnt_1 !== 1'b1 || if_rvalid_1 !== (k > 0) || (k > 0 && if_rdata_1 !== 32'hA0 + 32'(k - 1))) begin
            n_fail++;
            $display("[TB] FAIL b2b cycle %0d: got gnt=%b rv=%b rdata=%h", k, if_gnt_1, if_rvalid_1, if_rdata_1);
         end
         @(negedge clk);
      end
      if_req = 1'b0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      n_checks++;
      if ({if_gnt_1, if_rvalid_1} !== 2'b01 || if_rdata_1 !== 32'hA2) begin
         n_fail++;
         $display("[TB] FAIL b2b_last: got gnt,rv=%b rdata=%h expected 01 a2", {if_gnt_1, if_rvalid_1}, if_rdata_1);
      end
      @(negedge clk); #1;
      n_checks++;
      if (if_rvalid_1 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL b2b_end: got rv=%b expected 0", if_rvalid_1);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_arb_order();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
